ntt_coef_loader: RTL

//  Upstream feeder for the NTT/INTT core wrapper. Accepts one 16-bit coefficient per beat (valid/ready),

---
 rtl/ntt_loader_pkg.sv | 15 +
 rtl/ntt_coef_packer.sv | 48 ++++
 rtl/ntt_coef_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ntt_loader_pkg.sv
// Shared constants and state encoding for the NTT coefficient loader.
//   N   coefficients per frame
//   CW  coefficient width
//   AW  RAM word-address width (2**AW == N/2)
//   Q   modulus used by the optional range check (NTT_LOADER_RANGE_CHK_EN)
package ntt_loader_pkg;
  localparam int N  = 256;
  localparam int CW = 16;
  localparam int AW = 7;
  localparam int Q  = 3329;
  localparam int NW = N / 4;          // write cycles per frame (one word pair each)
  localparam int IW = $clog2(N) + 1;  // beat index width, must hold N itself

  typedef enum logic [2:0] {IDLE, FILL, FLUSH, DRAIN, WAIT} state_t;
endpackage

// File: rtl/ntt_coef_packer.sv
// Four-slot packing buffer for the NTT loader.
//   clk, rst   clock, synchronous active-high reset
//   clr        discard buffer contents (start of frame)
//   acc        coefficient accepted this cycle, value on data
//   flush      emit the buffer now, unfilled slots as zero
//   emit       a word pair is ready this cycle (word_a/word_b valid)
//   word_a     {slot1, slot0}
//   word_b     {slot3, slot2}
module ntt_coef_packer
  import ntt_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            acc,
  input  logic [CW-1:0]   data,
  input  logic            flush,
  output logic            emit,
  output logic [2*CW-1:0] word_a,
  output logic [2*CW-1:0] word_b
);
  logic [3:0][CW-1:0] slots, nb;
  logic [1:0]         slot;

  // Slots above the fill pointer are always zero because the buffer is
  // cleared on every emit, so a flush naturally yields the zero padding.
  always_comb begin
    nb = slots;
    if (acc) nb[slot] = data;
  end

  assign emit   = (acc && slot == 2'd3) || flush;
  assign word_a = {nb[1], nb[0]};
  assign word_b = {nb[3], nb[2]};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slots <= '0;
      slot  <= '0;
    end else if (emit) begin
      slots <= '0;
      slot  <= '0;
    end else if (acc) begin
      slots <= nb;
      slot  <= slot + 2'd1;
    end
  end
endmodule

// File: rtl/ntt_coef_loader.sv
// Upstream feeder for the NTT/INTT core: packs a stream of coefficients
// into word pairs, writes them to the core's dual-port load RAM while
// holding ntt_start, then waits for the core's done.
//   clk, rst            clock, synchronous active-high reset
//   go, mode_in         frame start pulse (idle only), mode latched on it
//   s_valid/s_ready     coefficient handshake; s_data, s_last frame marker
//   ntt_done            core done level, honoured only while waiting
//   ntt_start           high for the whole load phase
//   ntt_mode            latched mode
//   ntt_we, ntt_addr_a/b, ntt_data_a/b   RAM write port pair
//   busy, frame_done    frame in progress, completion pulse
//   err_len             sticky frame-length error
// Optional: NTT_LOADER_RANGE_CHK_EN adds err_range (sticky, coeff >= Q).
module ntt_coef_loader
  import ntt_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            mode_in,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [CW-1:0]   s_data,
  input  logic            s_last,
  input  logic            ntt_done,
  output logic            ntt_start,
  output logic            ntt_mode,
  output logic            ntt_we,
  output logic [AW-1:0]   ntt_addr_a,
  output logic [AW-1:0]   ntt_addr_b,
  output logic [2*CW-1:0] ntt_data_a,
  output logic [2*CW-1:0] ntt_data_b,
  output logic            busy,
  output logic            frame_done,
  output logic            err_len
`ifdef NTT_LOADER_RANGE_CHK_EN
  ,
  output logic            err_range
`endif
);
  state_t          state, nxt;
  logic [IW-1:0]   idx;      // beats accepted this frame
  logic [AW-1:0]   k;        // word pairs written this frame (0..NW)
  logic            wr_last;  // the write on the port now is the final pair
  logic            go_acc, acc, last_beat, flush_req, emit;
  logic [2*CW-1:0] word_a, word_b;

  assign go_acc    = go && state == IDLE;
  assign s_ready   = state == FILL && idx < IW'(N);
  assign acc       = s_valid && s_ready;
  assign last_beat = idx == IW'(N-1);
  assign flush_req = state == FLUSH && k < AW'(NW);
  assign ntt_start = state == FILL || state == FLUSH;
  assign busy      = state != IDLE;

  ntt_coef_packer u_pack (
    .clk    (clk),
    .rst    (rst),
    .clr    (go_acc),
    .acc    (acc),
    .data   (s_data),
    .flush  ((acc && s_last) || flush_req),
    .emit   (emit),
    .word_a (word_a),
    .word_b (word_b)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (go_acc) nxt = FILL;
      FILL:    if (wr_last) nxt = DRAIN;
               else if (acc && s_last && !last_beat) nxt = FLUSH;
      FLUSH:   if (wr_last) nxt = DRAIN;
      DRAIN:   nxt = WAIT;
      WAIT:    if (ntt_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      k          <= '0;
      wr_last    <= 1'b0;
      ntt_we     <= 1'b0;
      ntt_mode   <= 1'b0;
      ntt_addr_a <= '0;
      ntt_addr_b <= '0;
      ntt_data_a <= '0;
      ntt_data_b <= '0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= nxt;
      ntt_we     <= emit;
      wr_last    <= emit && k == AW'(NW-1);
      frame_done <= state == WAIT && ntt_done;
      if (go_acc) begin
        idx      <= '0;
        k        <= '0;
        err_len  <= 1'b0;
        ntt_mode <= mode_in;
      end else begin
        if (acc) idx <= idx + 1'b1;
        if (emit) begin
          k          <= k + 1'b1;
          ntt_addr_a <= {k[AW-2:0], 1'b0};
          ntt_addr_b <= {k[AW-2:0], 1'b1};
          ntt_data_a <= word_a;
          ntt_data_b <= word_b;
        end
        // Early s_last, or the final beat arriving without s_last.
        if (acc && (s_last != last_beat)) err_len <= 1'b1;
      end
    end
  end

`ifdef NTT_LOADER_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)                            err_range <= 1'b0;
    else if (go_acc)                    err_range <= 1'b0;
    else if (acc && s_data >= CW'(Q))   err_range <= 1'b1;
  end
`endif
endmodule
